// File: rtl/seq_fsm_ctx_pkg.sv
// Shared Moore machine definition: state encoding, transition table and
// output decode used by every requester context.
package seq_fsm_ctx_pkg;

  typedef enum logic [1:0] {
    A = 2'd0,
    B = 2'd1,
    C = 2'd2,
    D = 2'd3
  } state_t;

  // Transition table: in=0 / in=1
  //   A -> A / B;  B -> C / B;  C -> A / D;  D -> C / B
  function automatic state_t fsm_next(input state_t s, input logic in);
    state_t n;
    n = A;
    case (s)
      A:       n = in ? B : A;
      B:       n = in ? B : C;
      C:       n = in ? D : A;
      D:       n = in ? B : C;
      default: n = A;
    endcase
    return n;
  endfunction

  // Moore outputs packed as {out0, out1}
  function automatic logic [1:0] fsm_out(input state_t s);
    logic [1:0] o;
    o = 2'b00;
    case (s)
      A:       o = 2'b00;
      B:       o = 2'b01;
      C:       o = 2'b01;
      D:       o = 2'b10;
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_fsm_ctx_rr_sched_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// wrapping modulo NREQ. Purely combinational; the pointer lives in the parent.
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_val,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  // Scan from the farthest candidate back to ptr so the nearest valid one wins
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_val[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_fsm_ctx_rr_sched.sv
// Time-shares one Moore state machine among NREQ serial-bit requesters.
// Each requester has a saved state context; one granted bit per cycle advances
// its context, and the resulting state/outputs come back one cycle later.
//
// Handshake: a transfer happens for requester i in a cycle where
// req_val[i] & req_rdy[i]; req_rdy is a one-hot (or zero) combinational grant
// and never depends on the response side, which has no backpressure.
module seq_fsm_ctx_rr_sched
  import seq_fsm_ctx_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_val,
  input  logic [NREQ-1:0] req_bit,
  output logic [NREQ-1:0] req_rdy,
  input  logic [NREQ-1:0] ctx_clr,
  output logic            resp_val,
  output logic [IDW-1:0]  resp_id,
  output logic [1:0]      resp_state,
  output logic            resp_out0,
  output logic            resp_out1
);

  state_t          ctx [NREQ];
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  state_t          sel_state;
  logic            sel_bit;
  state_t          nxt_state;
  logic [1:0]      nxt_out;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_val   (req_val),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grant is suppressed while reset is held so nothing looks accepted
  assign req_rdy = reset ? '0 : grant;

  // Pick the granted requester's context and bit, then run the shared table
  always_comb begin
    sel_state = A;
    sel_bit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_state = ctx[i];
        sel_bit   = req_bit[i];
      end
    end
    nxt_state = fsm_next(sel_state, sel_bit);
    nxt_out   = fsm_out(nxt_state);
    ptr_nxt   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

  // Context array and rr pointer; a clear overrides a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) ctx[i] <= A;
      ptr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ctx_clr[i])    ctx[i] <= A;
        else if (grant[i]) ctx[i] <= nxt_state;
      end
      if (grant_any) ptr <= ptr_nxt;
    end
  end

  // Response register: loads on a transfer, otherwise holds with valid low
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_val   <= 1'b0;
      resp_id    <= '0;
      resp_state <= 2'b00;
      resp_out0  <= 1'b0;
      resp_out1  <= 1'b0;
    end else if (grant_any) begin
      resp_val   <= 1'b1;
      resp_id    <= grant_idx;
      resp_state <= nxt_state;
      resp_out0  <= nxt_out[1];
      resp_out1  <= nxt_out[0];
    end else begin
      resp_val   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_fsm_ctx_rr_sched.sv
// Bench for seq_fsm_ctx_rr_sched: directed vector table with hand-derived
// expectations, then random traffic checked against a table-lookup model.
module tb_seq_fsm_ctx_rr_sched;

  localparam int N   = 2;
  localparam int IDW = 2;
  localparam int W   = 1 + IDW + 2 + 2;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_bit;
  logic [N-1:0]   req_rdy;
  logic [N-1:0]   ctx_clr;
  logic           resp_val;
  logic [IDW-1:0] resp_id;
  logic [1:0]     resp_state;
  logic           resp_out0;
  logic           resp_out1;

  always #5 clk = ~clk;

  seq_fsm_ctx_rr_sched #(.NREQ(N), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_bit    (req_bit),
    .req_rdy    (req_rdy),
    .ctx_clr    (ctx_clr),
    .resp_val   (resp_val),
    .resp_id    (resp_id),
    .resp_state (resp_state),
    .resp_out0  (resp_out0),
    .resp_out1  (resp_out1)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: plain lookup tables and integer state per requester
  int nxt_tbl [4][2];
  int out_tbl [4];
  int m_ctx [N];
  int m_ptr;
  logic [W-1:0] m_last;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_ctx[i] = 0;
    m_ptr  = 0;
    m_last = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered at negedge; drives inputs, checks grant, advances the model,
  // samples the response #1 after posedge, returns at the next negedge.
  task automatic do_cycle(input logic rst_i, input logic [N-1:0] v,
                          input logic [N-1:0] b, input logic [N-1:0] c,
                          output logic [N-1:0] got_rdy,
                          output logic [W-1:0] got_resp);
    int g;
    int ns;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] e;
    reset   = rst_i;
    req_val = v;
    req_bit = b;
    ctx_clr = c;
    #1;
    g       = -1;
    exp_rdy = '0;
    if (!rst_i) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    got_rdy = req_rdy;
    check("grant", int'(req_rdy), int'(exp_rdy));

    if (rst_i) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        ns     = nxt_tbl[m_ctx[g]][b[g]];
        m_last = {1'b1, IDW'(g), 2'(ns), 2'(out_tbl[ns])};
        m_ctx[g] = ns;
        m_ptr    = (g + 1) % N;
      end else begin
        m_last[W-1] = 1'b0;
      end
      for (int i = 0; i < N; i++) if (c[i]) m_ctx[i] = 0;
    end
    exp_q.push_back(m_last);

    @(posedge clk);
    #1;
    got_resp = {resp_val, resp_id, resp_state, resp_out0, resp_out1};
    if (exp_q.size() == 0) begin
      check("resp_queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("resp_model", int'(got_resp), int'(e));
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [N-1:0] val;
    logic [N-1:0] bits;
    logic [N-1:0] clr;
    logic [N-1:0] rdy;
    logic       rv;
    int         id;
    int         st;
    logic [1:0] outs;
  } vec_t;

  vec_t vecs [24];

  initial begin
    logic [N-1:0] got_rdy;
    logic [W-1:0] got_resp;
    logic [W-1:0] exp_resp;
    logic         rst_r;
    logic [N-1:0] v_r, b_r, c_r;

    nxt_tbl = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
    out_tbl = '{0, 1, 1, 2};
    model_reset();

    //           rst val    bits   clr    rdy    rv id st outs
    vecs[0]  = '{1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00}; // reset
    vecs[1]  = '{0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // single stream B
    vecs[2]  = '{0, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 2, 2'b01}; // C
    vecs[3]  = '{0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 3, 2'b10}; // D
    vecs[4]  = '{0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // B
    vecs[5]  = '{0, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 2, 2'b01}; // C
    vecs[6]  = '{0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2, 2'b01}; // idle: hold
    vecs[7]  = '{1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00}; // reset
    vecs[8]  = '{0, 2'b11, 2'b11, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // alternate r0 B
    vecs[9]  = '{0, 2'b11, 2'b11, 2'b00, 2'b10, 1, 1, 1, 2'b01}; // r1 B
    vecs[10] = '{0, 2'b11, 2'b01, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // r0 B
    vecs[11] = '{0, 2'b11, 2'b01, 2'b00, 2'b10, 1, 1, 2, 2'b01}; // r1 C
    vecs[12] = '{0, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 2, 2'b01}; // r0 -> C
    vecs[13] = '{0, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0, 3, 2'b10}; // clear collision D
    vecs[14] = '{0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // from A -> B
    vecs[15] = '{0, 2'b10, 2'b10, 2'b00, 2'b10, 1, 1, 3, 2'b10}; // sparse r1 D
    vecs[16] = '{0, 2'b10, 2'b10, 2'b00, 2'b10, 1, 1, 1, 2'b01}; // r1 B
    vecs[17] = '{0, 2'b10, 2'b10, 2'b00, 2'b10, 1, 1, 1, 2'b01}; // r1 B
    vecs[18] = '{0, 2'b11, 2'b10, 2'b00, 2'b01, 1, 0, 2, 2'b01}; // r0 favoured: C
    vecs[19] = '{0, 2'b11, 2'b10, 2'b00, 2'b10, 1, 1, 1, 2'b01}; // r1 B
    vecs[20] = '{1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00}; // mid-stream reset
    vecs[21] = '{0, 2'b11, 2'b11, 2'b00, 2'b01, 1, 0, 1, 2'b01}; // r0 first, from A
    vecs[22] = '{0, 2'b10, 2'b00, 2'b01, 2'b10, 1, 1, 0, 2'b00}; // clear idle r0
    vecs[23] = '{0, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0, 0, 2'b00}; // r0 was cleared

    reset   = 1'b1;
    req_val = '0;
    req_bit = '0;
    ctx_clr = '0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      do_cycle(vecs[i].rst, vecs[i].val, vecs[i].bits, vecs[i].clr, got_rdy, got_resp);
      exp_resp = {vecs[i].rv, IDW'(vecs[i].id), 2'(vecs[i].st), vecs[i].outs};
      check($sformatf("vec%0d_rdy", i), int'(got_rdy), int'(vecs[i].rdy));
      check($sformatf("vec%0d_resp", i), int'(got_resp), int'(exp_resp));
    end

    // ---------------- random traffic against the model ----------------
    for (int i = 0; i < 400; i++) begin
      rst_r = ($urandom_range(0, 39) == 0);
      v_r   = N'($urandom_range(0, (1 << N) - 1));
      b_r   = N'($urandom_range(0, (1 << N) - 1));
      c_r   = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      do_cycle(rst_r, v_r, b_r, c_r, got_rdy, got_resp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
